// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
// Define UART_RX_FRAME_CHECK_EN to enable stop-bit checking and the o_Rx_Frame_Err port.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy
`ifdef UART_RX_FRAME_CHECK_EN
  ,
  output logic       o_Rx_Frame_Err
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state,     state_nxt;
  logic [CNT_W-1:0] cnt,       cnt_nxt;
  logic [IDX_W-1:0] idx,       idx_nxt;
  logic [7:0]       shreg,     shreg_nxt;
  logic [7:0]       byte_nxt;
  logic             dv_nxt;
`ifdef UART_RX_FRAME_CHECK_EN
  logic             ferr_nxt;
`endif

  // Two-flop synchroniser on the asynchronous pin; idles high.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Busy      <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      o_Rx_Frame_Err <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      shreg          <= shreg_nxt;
      o_Rx_Byte      <= byte_nxt;
      o_Rx_DV        <= dv_nxt;
      o_Rx_Busy      <= (state_nxt != IDLE);
`ifdef UART_RX_FRAME_CHECK_EN
      o_Rx_Frame_Err <= ferr_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    byte_nxt  = o_Rx_Byte;
    dv_nxt    = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    ferr_nxt  = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == IDX_W'(7)) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = CLEANUP;
`ifdef UART_RX_FRAME_CHECK_EN
          if (rx_s) begin
            byte_nxt = shreg;
            dv_nxt   = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
`else
          byte_nxt = shreg;
          dv_nxt   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      CLEANUP: begin
        // Wait for a high line so a held-low break cannot retrigger a start.
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a 16-clk/bit instance for the functional cases
// and an 868-clk/bit instance for the baud-tolerance cases.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1;
  logic       rx868 = 1'b1;
  logic       dv16, dv868, busy16, busy868;
  logic [7:0] byte16, byte868;
`ifdef UART_RX_FRAME_CHECK_EN
  logic       ferr16, ferr868;
  int         nferr = 0;
`endif

  int total = 0;
  int bad = 0;
  int lat;
  int n0;
  logic [7:0] q16[$];
  logic [7:0] q868[$];

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx16),
    .o_Rx_DV(dv16), .o_Rx_Byte(byte16), .o_Rx_Busy(busy16)
`ifdef UART_RX_FRAME_CHECK_EN
    , .o_Rx_Frame_Err(ferr16)
`endif
  );

  uart_receiver #(.CLKS_PER_BIT(868)) dut868 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx868),
    .o_Rx_DV(dv868), .o_Rx_Byte(byte868), .o_Rx_Busy(busy868)
`ifdef UART_RX_FRAME_CHECK_EN
    , .o_Rx_Frame_Err(ferr868)
`endif
  );

  // Collect every strobe; outputs are sampled on the inactive edge.
  always @(negedge clk) begin
    if (dv16)  q16.push_back(byte16);
    if (dv868) q868.push_back(byte868);
`ifdef UART_RX_FRAME_CHECK_EN
    if (ferr16) nferr++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx16 = v;
    else rx868 = v;
  endtask

  // Called right after a falling clock edge; drives one full 8N1 frame.
  task automatic send_byte(input int sel, input int blen, input logic [7:0] b, input logic stop_bit);
    drive(sel, 1'b0);
    repeat (blen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (blen) @(negedge clk);
    end
    drive(sel, stop_bit);
    repeat (blen) @(negedge clk);
    drive(sel, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dv", 32'(dv16), 32'h0);
    check("rst_byte", 32'(byte16), 32'h00);
    check("rst_busy", 32'(busy16), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame with latency measurement: DV at negedge 2+H+9*16+1 = 155.
    lat = 0;
    fork
      send_byte(0, 16, 8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (dv16) begin
            lat = k;
            break;
          end
        end
      end
    join
    repeat (20) @(negedge clk);
    check("a5_latency", 32'(lat), 32'd155);
    check("a5_count", 32'(q16.size()), 32'd1);
    check("a5_byte", 32'(byte16), 32'hA5);
    check("a5_busy_after", 32'(busy16), 32'h0);

    // Back-to-back frames with no idle bits.
    send_byte(0, 16, 8'h00, 1'b1);
    send_byte(0, 16, 8'hFF, 1'b1);
    send_byte(0, 16, 8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", 32'(q16.size()), 32'd4);
    if (q16.size() == 4) begin
      check("b2b_0", 32'(q16[1]), 32'h00);
      check("b2b_1", 32'(q16[2]), 32'hFF);
      check("b2b_2", 32'(q16[3]), 32'h3C);
    end

    // Short low glitch must be rejected at the start-bit check.
    rx16 = 1'b0;
    repeat (5) @(negedge clk);
    rx16 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", 32'(q16.size()), 32'd4);
    check("glitch_busy", 32'(busy16), 32'h0);
    check("glitch_byte", 32'(byte16), 32'h3C);

    // Low stop bit, then a 40-cycle break, then a good frame.
    n0 = q16.size();
    send_byte(0, 16, 8'h5A, 1'b0);
    rx16 = 1'b0;
    repeat (40) @(negedge clk);
    rx16 = 1'b1;
    repeat (48) @(negedge clk);
    send_byte(0, 16, 8'h81, 1'b1);
    repeat (20) @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
    check("ferr_pulses", 32'(nferr), 32'd1);
    check("ferr_count", 32'(q16.size() - n0), 32'd1);
`else
    check("stop_ignored_count", 32'(q16.size() - n0), 32'd2);
    if (q16.size() - n0 == 2) check("stop_ignored_byte", 32'(q16[n0]), 32'h5A);
`endif
    check("after_break_byte", 32'(byte16), 32'h81);

    // Reset in the middle of data bit 4 of an all-zero frame.
    n0 = q16.size();
    rx16 = 1'b0;
    repeat (16 * 5 + 8) @(negedge clk);
    check("mid_frame_busy", 32'(busy16), 32'h1);
    rst = 1'b1;
    rx16 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_dv", 32'(dv16), 32'h0);
    check("rst_mid_byte", 32'(byte16), 32'h00);
    check("rst_mid_busy", 32'(busy16), 32'h0);
`ifdef UART_RX_FRAME_CHECK_EN
    check("rst_mid_ferr", 32'(ferr16), 32'h0);
`endif
    repeat (48) @(negedge clk);
    check("rst_no_strobe", 32'(q16.size() - n0), 32'd0);
    send_byte(0, 16, 8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check("c3_count", 32'(q16.size() - n0), 32'd1);
    check("c3_byte", 32'(byte16), 32'hC3);

    // Baud tolerance at 868 clk/bit: 3% fast (842) and 3% slow (894).
    send_byte(1, 842, 8'h96, 1'b1);
    repeat (900) @(negedge clk);
    send_byte(1, 894, 8'h69, 1'b1);
    repeat (900) @(negedge clk);
    check("tol_count", 32'(q868.size()), 32'd2);
    if (q868.size() == 2) begin
      check("tol_fast", 32'(q868[0]), 32'h96);
      check("tol_slow", 32'(q868[1]), 32'h69);
    end
    check("tol_busy", 32'(busy868), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
